read_channel_native: RTL

// Line-fill engine for the cache back-end: on a miss it fetches one full cache line from memory

---
 rtl/read_channel_native_pkg.sv | 15 +
 rtl/read_channel_native.sv | 102 ++++++++++
 2 files changed

// File: rtl/read_channel_native_pkg.sv
// Width helpers for the line-fill read channel.
// These are shared so that port widths and the LINE2MEM_W derivation stay in one place.
package read_channel_native_pkg;

   // log2 of BE beats per cache line (0 = the whole line fits in one BE word)
   function automatic int calc_line2mem_w(input int word_off_w, input int fe_data_w,
                                          input int be_data_w);
      return word_off_w - $clog2(be_data_w / fe_data_w);
   endfunction

   function automatic int at_least_one(input int w);
      return (w > 0) ? w : 1;
   endfunction

endpackage

// File: rtl/read_channel_native.sv
// Line-fill engine: fetches one cache line over valid/ready, forwarding each beat to data memory.
// Latency 2^LINE2MEM_W beats + 1 END cycle at zero wait; stalls indefinitely on mem_ready, never drops mem_valid mid-line.
module read_channel_native
   import read_channel_native_pkg::*;
#(
   parameter int FE_ADDR_W  = 32,
   parameter int FE_DATA_W  = 32,
   parameter int BE_ADDR_W  = FE_ADDR_W,
   parameter int BE_DATA_W  = FE_DATA_W,
   parameter int WORD_OFF_W = 3,
   localparam int BE_BYTE_W  = $clog2(BE_DATA_W / 8),
   localparam int LINE2MEM_W = calc_line2mem_w(WORD_OFF_W, FE_DATA_W, BE_DATA_W),
   localparam int RADDR_W    = at_least_one(LINE2MEM_W)
)(
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic                                    replace_valid,
   input  logic [FE_ADDR_W-BE_BYTE_W-LINE2MEM_W-1:0] replace_addr,
   output logic                                    replace,
   output logic                                    read_valid,
   output logic [RADDR_W-1:0]                      read_addr,
   output logic [BE_DATA_W-1:0]                    read_data,
   output logic [BE_ADDR_W-1:0]                    mem_addr,
   output logic                                    mem_valid,
   input  logic [BE_DATA_W-1:0]                    mem_rdata,
   input  logic                                    mem_ready
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_END  = 2'd2;

   logic [1:0]           state;
   logic [1:0]           state_nxt;
   logic                 last_beat;
   logic [RADDR_W-1:0]   word_idx;
   logic [FE_ADDR_W-1:0] line_byte_addr;

   generate
      if (LINE2MEM_W > 0) begin : g_burst
         logic [LINE2MEM_W-1:0] word_counter;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               word_counter <= '0;
            end else if (state == ST_IDLE) begin
               word_counter <= '0;
            end else if ((state == ST_LOAD) && mem_ready) begin
               word_counter <= word_counter + 1'b1;
            end
         end

         assign last_beat      = &word_counter;
         assign word_idx       = word_counter;
         assign line_byte_addr = {replace_addr, word_counter, {BE_BYTE_W{1'b0}}};
      end else begin : g_single
         // whole line arrives in one BE word, so the first beat is also the last
         assign last_beat      = 1'b1;
         assign word_idx       = '0;
         assign line_byte_addr = {replace_addr, {BE_BYTE_W{1'b0}}};
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (replace_valid) state_nxt = ST_LOAD;
         ST_LOAD: if (mem_ready && last_beat) state_nxt = ST_END;
         ST_END:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // END keeps replace high one extra cycle so the last data-memory write lands
   always_comb begin
      replace    = 1'b0;
      mem_valid  = 1'b0;
      read_valid = 1'b0;
      case (state)
         ST_LOAD: begin
            replace    = 1'b1;
            mem_valid  = 1'b1;
            read_valid = mem_ready;
         end
         ST_END:  replace = 1'b1;
         default: ;
      endcase
   end

   assign read_addr = word_idx;
   assign read_data = mem_rdata;
   assign mem_addr  = BE_ADDR_W'(line_byte_addr);

endmodule
